cp_insert: RTL and testbench
============================

Name: cp_insert

Overview:
- Final stage of the IFFT_CP chain. Sits directly downstream of the last radix-4 SDF butterfly stage and its twiddle/reorder logic.
- Accepts time-domain IFFT output samples in natural order, N per symbol, and buffers each symbol in a ping-pong RAM.
- Emits each symbol with its cyclic prefix prepended: the last CP_LEN samples, then all N samples.
- Output is a continuous stream for the PUSCH transmit path.

Parameters:
- WIDTH, 26, bit width of each real/imag sample component.
- N, 2048, IFFT size (samples per symbol); power of two.
- CP_LEN, 144, cyclic prefix length in samples; 1 <= CP_LEN < N.
- AW, 11, address width, log2(N).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- data_in_r  in  WIDTH  signed real input sample.
- data_in_i  in  WIDTH  signed imag input sample.
- VALID  in  1  input sample qualifier, one sample per asserted cycle.
- IN_READY  out  1  high when the write bank can accept a sample.
- data_out_r  out  WIDTH  signed real output sample.
- data_out_i  out  WIDTH  signed imag output sample.
- OUT_VALID  out  1  output sample qualifier.
- SYM_START  out  1  pulses with the first CP sample of each symbol.
- OVERFLOW  out  1  sticky: a sample arrived while IN_READY was low.

Behaviour:
- Reset (rst=0, async): all outputs 0; both banks empty; write bank 0; write counter 0; read FSM in R_IDLE; OVERFLOW cleared. A reset mid-symbol discards all buffered data.
- Storage: 2 banks x N words of {real, imag}. Address = {bank, index}.
- Write side:
  - Sample accepted when VALID=1 and bank_full[wr_bank]=0. It is written at wr_cnt, then wr_cnt increments.
  - At wr_cnt = N-1: set bank_full[wr_bank], clear wr_cnt, toggle wr_bank.
  - IN_READY = ~bank_full[wr_bank], combinational from registers.
  - VALID=1 while IN_READY=0: sample dropped, wr_cnt unchanged, OVERFLOW set and held until reset.
- Read FSM (rd_bank starts 0):
  - R_IDLE: if bank_full[rd_bank], go to R_CP with rd_idx = N-CP_LEN.
  - R_CP: issue one read per cycle. When rd_idx reaches N-1, rd_idx wraps to 0 and FSM goes to R_BODY.
  - R_BODY: issue one read per cycle. On the rd_idx = N-1 issue cycle: clear bank_full[rd_bank] and toggle rd_bank.
    - If the other bank is already full, or becomes full the same cycle, go directly to R_CP with no gap.
    - Otherwise go to R_IDLE.
- Simultaneous events: a bank_full set (write side) and clear (read side) on different banks in the same cycle both take effect. A write into the bank being released that same cycle is not possible because IN_READY was low.
- Output pipeline: RAM read is synchronous (1 cycle), followed by an output register (1 cycle).
  - data_out_*, OUT_VALID and SYM_START are all registered and mutually aligned.
  - The first CP sample appears on the 3rd rising edge after the edge that accepted sample N-1 of a symbol.
- OUT_VALID is high for exactly N+CP_LEN consecutive cycles per symbol. SYM_START is high only on the first of them.
- data_out_* holds its last value when OUT_VALID=0.
- Data passes through bit-exact; no arithmetic and no width change.
- Sustained throughput: upstream must leave >= CP_LEN idle cycles per symbol on average. Otherwise OVERFLOW will set.

Decomposition:
- Shared package cp_pkg holds:
  - Default N, CP_LEN, WIDTH, AW constants.
  - Read FSM state encoding: R_IDLE = 2'b00, R_CP = 2'b01, R_BODY = 2'b10.
  - The complex sample struct/typedef {real, imag}.
- One sub-module, cp_sym_ram: simple dual-port RAM, 2N x 2*WIDTH, with one write port, one read port and registered read data. It infers block RAM.
- The bank/FSM control lives in cp_insert.

Test Plan:
- Small config N=16, CP_LEN=4. Feed one symbol with real=k, imag=-k for k=0..15, contiguous -> OUT_VALID for 20 cycles. Output real sequence is 12,13,14,15,0,1,...,15. SYM_START is high only on the first (12). First output arrives 3 edges after k=15 is accepted.
- Two symbols back-to-back (values 0..15, then 100..115) with 4-cycle gaps -> 40 contiguous OUT_VALID cycles. The second SYM_START lands at real=112. OVERFLOW stays 0.
- Three contiguous symbols with no gaps -> IN_READY drops while both banks are full. The sample presented during that window is dropped and OVERFLOW=1 persists. Symbols 1 and 2 are output correctly.
- Assert rst mid-way through the R_BODY output of symbol 1 -> outputs go to 0 immediately and OVERFLOW=0. A new symbol afterwards is output correctly from bank 0.
- Extreme values: real=2^25-1, imag=-2^25 on all samples -> outputs are bit-exact, with no sign corruption.
- Default config N=2048, CP_LEN=144, random data -> the output matches a golden model: tail[1904..2047] followed by the full symbol, 2192 samples.

Source files
------------

// File: rtl/cp_pkg.sv
// Shared constants, read-FSM encoding and sample type for the cyclic-prefix
// insertion stage at the tail of the IFFT_CP chain.
package cp_pkg;

    localparam int CP_WIDTH  = 26;
    localparam int CP_N      = 2048;
    localparam int CP_CP_LEN = 144;
    localparam int CP_AW     = 11;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_CP   = 2'b01,
        R_BODY = 2'b10
    } rd_state_t;

    typedef struct packed {
        logic signed [CP_WIDTH-1:0] re;
        logic signed [CP_WIDTH-1:0] im;
    } cp_sample_t;

endpackage

// File: rtl/cp_sym_ram.sv
// Simple dual-port symbol buffer: one write port, one read port, registered
// read data. No reset on the array or read register so it maps to block RAM.
module cp_sym_ram #(
    parameter int DW     = 52,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cp_insert.sv
// Ping-pong symbol buffer that replays each N-sample symbol with its last
// CP_LEN samples prepended, producing a gap-free stream when input keeps up.
module cp_insert
    import cp_pkg::*;
#(
    parameter int WIDTH  = CP_WIDTH,
    parameter int N      = CP_N,
    parameter int CP_LEN = CP_CP_LEN,
    parameter int AW     = CP_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] data_in_r,
    input  logic signed [WIDTH-1:0] data_in_i,
    input  logic                    VALID,
    output logic                    IN_READY,
    output logic signed [WIDTH-1:0] data_out_r,
    output logic signed [WIDTH-1:0] data_out_i,
    output logic                    OUT_VALID,
    output logic                    SYM_START,
    output logic                    OVERFLOW
);

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } sample_t;

    localparam int              ADDR_W   = AW + 1;
    localparam logic [AW-1:0]   CP_FIRST = AW'(N - CP_LEN);
    localparam logic [AW-1:0]   IDX_LAST = AW'(N - 1);

    // Write side
    logic [1:0]    bank_full_reg;
    logic [1:0]    bank_full_next;
    logic          wr_bank_reg;
    logic [AW-1:0] wr_cnt_reg;
    logic          overflow_reg;
    logic          accept;
    logic          wr_done;
    sample_t       wr_word;

    // Read side
    rd_state_t     rd_state_reg;
    logic          rd_bank_reg;
    logic [AW-1:0] rd_idx_reg;
    logic          rd_issue;
    logic          rd_first;
    logic          rd_done;
    logic          other_full;

    // Output pipeline
    sample_t       ram_rdata;
    logic          ram_valid_reg;
    logic          ram_first_reg;
    sample_t       out_reg;
    logic          out_valid_reg;
    logic          sym_start_reg;

    assign IN_READY = ~bank_full_reg[wr_bank_reg];
    assign accept   = VALID & IN_READY;
    assign wr_done  = accept && (wr_cnt_reg == IDX_LAST);
    assign wr_word  = {data_in_r, data_in_i};

    assign rd_issue = (rd_state_reg == R_CP) || (rd_state_reg == R_BODY);
    assign rd_first = (rd_state_reg == R_CP) && (rd_idx_reg == CP_FIRST);
    assign rd_done  = (rd_state_reg == R_BODY) && (rd_idx_reg == IDX_LAST);

    // A bank completing on the write side this very cycle counts as full so
    // the next symbol follows without a bubble.
    assign other_full = bank_full_reg[~rd_bank_reg]
                      | (wr_done & (wr_bank_reg == ~rd_bank_reg));

    always_comb begin
        bank_full_next = bank_full_reg;
        if (wr_done) begin
            bank_full_next[wr_bank_reg] = 1'b1;
        end
        if (rd_done) begin
            bank_full_next[rd_bank_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full_reg <= '0;
            wr_bank_reg   <= 1'b0;
            wr_cnt_reg    <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            bank_full_reg <= bank_full_next;
            if (VALID && !IN_READY) begin
                overflow_reg <= 1'b1;
            end
            if (accept) begin
                if (wr_cnt_reg == IDX_LAST) begin
                    wr_cnt_reg  <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_cnt_reg <= wr_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_reg <= R_IDLE;
            rd_bank_reg  <= 1'b0;
            rd_idx_reg   <= '0;
        end else begin
            case (rd_state_reg)
                R_IDLE: begin
                    if (bank_full_reg[rd_bank_reg]) begin
                        rd_state_reg <= R_CP;
                        rd_idx_reg   <= CP_FIRST;
                    end
                end
                R_CP: begin
                    if (rd_idx_reg == IDX_LAST) begin
                        rd_idx_reg   <= '0;
                        rd_state_reg <= R_BODY;
                    end else begin
                        rd_idx_reg <= rd_idx_reg + 1'b1;
                    end
                end
                R_BODY: begin
                    if (rd_idx_reg == IDX_LAST) begin
                        rd_bank_reg <= ~rd_bank_reg;
                        if (other_full) begin
                            rd_state_reg <= R_CP;
                            rd_idx_reg   <= CP_FIRST;
                        end else begin
                            rd_state_reg <= R_IDLE;
                        end
                    end else begin
                        rd_idx_reg <= rd_idx_reg + 1'b1;
                    end
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    cp_sym_ram #(
        .DW     ($bits(sample_t)),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wr_bank_reg, wr_cnt_reg}),
        .wdata (wr_word),
        .re    (rd_issue),
        .raddr ({rd_bank_reg, rd_idx_reg}),
        .rdata (ram_rdata)
    );

    // Qualifiers travel alongside the RAM latency so all outputs stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_valid_reg <= 1'b0;
            ram_first_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            sym_start_reg <= 1'b0;
            out_reg       <= '0;
        end else begin
            ram_valid_reg <= rd_issue;
            ram_first_reg <= rd_first;
            out_valid_reg <= ram_valid_reg;
            sym_start_reg <= ram_first_reg;
            if (ram_valid_reg) begin
                out_reg <= ram_rdata;
            end
        end
    end

    assign data_out_r = out_reg.re;
    assign data_out_i = out_reg.im;
    assign OUT_VALID  = out_valid_reg;
    assign SYM_START  = sym_start_reg;
    assign OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: a small N=16/CP=4 instance for directed
// cases and a default-size instance checked against a golden tail+body model.
module tb_cp_insert;

    localparam int W   = 26;
    localparam int SN  = 16;
    localparam int SCP = 4;
    localparam int SAW = 4;
    localparam int BN  = 2048;
    localparam int BCP = 144;
    localparam int BAW = 11;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sos;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_s, valid_s, in_ready_s, out_valid_s, sym_start_s, overflow_s;
    logic [W-1:0] din_r_s, din_i_s, dout_r_s, dout_i_s;
    logic         rst_b, valid_b, in_ready_b, out_valid_b, sym_start_b, overflow_b;
    logic [W-1:0] din_r_b, din_i_b, dout_r_b, dout_i_b;

    cp_insert #(.WIDTH(W), .N(SN), .CP_LEN(SCP), .AW(SAW)) dut_s (
        .clk(clk), .rst(rst_s), .data_in_r(din_r_s), .data_in_i(din_i_s),
        .VALID(valid_s), .IN_READY(in_ready_s), .data_out_r(dout_r_s),
        .data_out_i(dout_i_s), .OUT_VALID(out_valid_s), .SYM_START(sym_start_s),
        .OVERFLOW(overflow_s)
    );

    cp_insert #(.WIDTH(W), .N(BN), .CP_LEN(BCP), .AW(BAW)) dut_b (
        .clk(clk), .rst(rst_b), .data_in_r(din_r_b), .data_in_i(din_i_b),
        .VALID(valid_b), .IN_READY(in_ready_b), .data_out_r(dout_r_b),
        .data_out_i(dout_i_b), .OUT_VALID(out_valid_b), .SYM_START(sym_start_b),
        .OVERFLOW(overflow_b)
    );

    int checks = 0;
    int errors = 0;
    exp_t q_s[$];
    exp_t q_b[$];
    int run_s = 0, last_run_s = 0, drops_s = 0;
    int run_b = 0, last_run_b = 0, drops_b = 0;
    logic [W-1:0] sre [BN];
    logic [W-1:0] sim_ [BN];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            sre[k]  = W'(base + k);
            sim_[k] = '0 - W'(base + k);
        end
    endtask

    task automatic push_exp(input bit big);
        int n, cp, idx;
        exp_t e;
        n  = big ? BN : SN;
        cp = big ? BCP : SCP;
        for (int j = 0; j < cp + n; j++) begin
            idx   = (j < cp) ? (n - cp + j) : (j - cp);
            e.re  = sre[idx];
            e.im  = sim_[idx];
            e.sos = (j == 0);
            if (big) q_b.push_back(e);
            else     q_s.push_back(e);
        end
    endtask

    // Called just after a falling edge; the sample is taken on the next rising edge.
    task automatic drive_s(input logic [W-1:0] re, input logic [W-1:0] im);
        din_r_s = re; din_i_s = im; valid_s = 1'b1;
        #1 if (!in_ready_s) drops_s++;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic [W-1:0] re, input logic [W-1:0] im);
        din_r_b = re; din_i_b = im; valid_b = 1'b1;
        #1 if (!in_ready_b) drops_b++;
        @(negedge clk);
    endtask

    task automatic feed_s();
        for (int k = 0; k < SN; k++) drive_s(sre[k], sim_[k]);
    endtask

    task automatic drain_s(input string tag, input int budget);
        int c = 0;
        while ((q_s.size() != 0 || out_valid_s) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, q_s.size(), 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (out_valid_s) begin
            run_s++;
            if (q_s.size() == 0) check("s_unexpected_out", 1, 0);
            else begin
                e = q_s.pop_front();
                check("s_re", dout_r_s, e.re);
                check("s_im", dout_i_s, e.im);
                check("s_sym_start", sym_start_s, e.sos);
            end
        end else if (run_s > 0) begin
            last_run_s = run_s;
            run_s = 0;
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (out_valid_b) begin
            run_b++;
            if (q_b.size() == 0) check("b_unexpected_out", 1, 0);
            else begin
                e = q_b.pop_front();
                check("b_re", dout_r_b, e.re);
                check("b_im", dout_i_b, e.im);
                check("b_sym_start", sym_start_b, e.sos);
            end
        end else if (run_b > 0) begin
            last_run_b = run_b;
            run_b = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst_s = 1'b1; rst_b = 1'b1;
        valid_s = 1'b0; valid_b = 1'b0;
        din_r_s = '0; din_i_s = '0; din_r_b = '0; din_i_b = '0;
        #1 rst_s = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_out_valid", out_valid_s, 0);
        check("rst_data_r", dout_r_s, 0);
        check("rst_sym_start", sym_start_s, 0);
        check("rst_overflow", overflow_s, 0);
        check("rst_in_ready", in_ready_s, 1);
        repeat (3) @(negedge clk);
        rst_s = 1'b1; rst_b = 1'b1;
        @(negedge clk);

        // Single symbol, latency and hold-when-idle
        fill(0, SN);
        push_exp(0);
        feed_s();
        valid_s = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("lat_edge2_valid", out_valid_s, 0);
        @(posedge clk); @(negedge clk);
        check("lat_edge3_valid", out_valid_s, 1);
        check("lat_edge3_sym_start", sym_start_s, 1);
        check("lat_edge3_re", dout_r_s, 12);
        drain_s("t1_drain", 100);
        check("t1_run_len", last_run_s, SN + SCP);
        check("t1_hold_re", dout_r_s, 15);

        // Two symbols with 4-cycle gap, expect gap-free 40 outputs
        fill(0, SN);   push_exp(0); feed_s();
        valid_s = 1'b0;
        repeat (4) @(negedge clk);
        fill(100, SN); push_exp(0); feed_s();
        valid_s = 1'b0;
        drain_s("t2_drain", 200);
        check("t2_run_len", last_run_s, 2 * (SN + SCP));
        check("t2_overflow", overflow_s, 0);

        // Three contiguous symbols: first CP_LEN+1 samples of the third are dropped
        drops_s = 0;
        fill(200, SN); push_exp(0); feed_s();
        fill(300, SN); push_exp(0); feed_s();
        fill(400, SN); feed_s();
        valid_s = 1'b0;
        check("t3_drops", drops_s, SCP + 1);
        check("t3_overflow", overflow_s, 1);
        drain_s("t3_drain", 200);
        check("t3_run_len", last_run_s, 2 * (SN + SCP));
        check("t3_overflow_sticky", overflow_s, 1);

        // Complete the partial bank, then reset in the middle of its body
        for (int k = 0; k < SN - SCP - 1; k++) begin
            sre[k]  = W'(400 + SCP + 1 + k);
            sim_[k] = '0 - W'(400 + SCP + 1 + k);
        end
        for (int k = 0; k <= SCP; k++) begin
            sre[SN - SCP - 1 + k]  = W'(500 + k);
            sim_[SN - SCP - 1 + k] = '0 - W'(500 + k);
        end
        push_exp(0);
        for (int k = 0; k <= SCP; k++) drive_s(W'(500 + k), '0 - W'(500 + k));
        valid_s = 1'b0;
        c = 0;
        while (q_s.size() > 10 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("t4_mid_body_reached", q_s.size() <= 10, 1);
        @(posedge clk);
        #2 rst_s = 1'b0;
        #1;
        check("t4_rst_out_valid", out_valid_s, 0);
        check("t4_rst_data_r", dout_r_s, 0);
        check("t4_rst_data_i", dout_i_s, 0);
        check("t4_rst_overflow", overflow_s, 0);
        check("t4_rst_in_ready", in_ready_s, 1);
        q_s.delete();
        @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        fill(600, SN); push_exp(0); feed_s();
        valid_s = 1'b0;
        drain_s("t4_drain", 100);
        check("t4_run_len", last_run_s, SN + SCP);

        // Extreme values
        for (int k = 0; k < SN; k++) begin
            sre[k]  = {1'b0, {(W-1){1'b1}}};
            sim_[k] = {1'b1, {(W-1){1'b0}}};
        end
        push_exp(0); feed_s();
        valid_s = 1'b0;
        drain_s("t5_drain", 100);
        check("t5_last_im", dout_i_s, {1'b1, {(W-1){1'b0}}});

        // Default configuration with random data
        for (int k = 0; k < BN; k++) begin
            sre[k]  = W'($urandom);
            sim_[k] = W'($urandom);
        end
        push_exp(1);
        for (int k = 0; k < BN; k++) drive_b(sre[k], sim_[k]);
        valid_b = 1'b0;
        c = 0;
        while ((q_b.size() != 0 || out_valid_b) && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("t6_drain", q_b.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        check("t6_run_len", last_run_b, BN + BCP);
        check("t6_drops", drops_b, 0);
        check("t6_overflow", overflow_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
